// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register plus operand forwarding for the ALU of a 5-stage
// pipeline. Decoded fields are captured each edge. rs1/rs2 are resolved
// against the EX/MEM and MEM/WB result buses, with EX/MEM taking precedence.
// A load-use hazard raises a combinational stall request to decode and inserts
// a bubble into EX.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   id_*                  decoded instruction fields from the decode stage
//   stall                 hold the EX slot (downstream back-pressure)
//   flush                 kill the EX slot (taken branch / jump)
//   exmem_*               EX/MEM forwarding source (write enable, rd, result)
//   memwb_*               MEM/WB forwarding source (write enable, rd, data)
//   alu_a, alu_b          forwarded ALU operands
//   alu_ctrl_o            ALU operation code
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd
//                         registered control for the downstream stages
//   ex_store_data         forwarded rs2, used as store data
//   load_use_stall        decode must hold this cycle
//
// Configuration macro: OPERAND_ISOLATION_EN
//   When defined, the operand outputs are forced to 0 while the EX slot is
//   empty. The data registers also skip loading on bubbles and invalid slots,
//   which keeps the ALU inputs quiet. When undefined, the outputs follow the
//   registers and the data fields load on every non-stalled edge.
// -----------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic            id_uses_rs2,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl_o,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);

    // Registered data fields of the EX slot.
    logic [3:0]      ex_alu_ctrl;
    logic [REGW-1:0] ex_rs1;
    logic [REGW-1:0] ex_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;

    logic            bubble;     // control bits cleared at this edge
    logic            capture;    // control bits loaded from decode at this edge
    logic            load_data;  // data fields loaded from decode at this edge
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // The load in EX writes ex_rd, and decode reads it this cycle. rs1 is
    // compared whenever the slot is valid. rs2 is compared only if it is used.
    assign load_use_stall = id_valid && ex_valid && ex_mem_read
                         && (ex_rd != '0)
                         && ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Priority: flush > stall > load-use bubble > capture.
    assign bubble  = flush || (!stall && load_use_stall);
    assign capture = !flush && !stall && !load_use_stall;

`ifdef OPERAND_ISOLATION_EN
    assign load_data = capture && id_valid;
`else
    assign load_data = flush || !stall;
`endif

    // Control half of the ID/EX register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values, whatever the statement order.
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (capture) begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write && id_valid;
            ex_mem_read  <= id_mem_read  && id_valid;
            ex_mem_write <= id_mem_write && id_valid;
        end
    end

    // Data half of the ID/EX register. These fields are cleared on reset so
    // that the indices are 0, which makes the forwarded outputs 0 as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_alu_ctrl <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            rs1_data    <= '0;
            rs2_data    <= '0;
            imm         <= '0;
            alu_src     <= 1'b0;
        end else if (load_data) begin
            ex_alu_ctrl <= id_alu_ctrl;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            rs1_data    <= id_rs1_data;
            rs2_data    <= id_rs2_data;
            imm         <= id_imm;
            alu_src     <= id_alu_src;
        end
    end

    // Forwarding muxes. EX/MEM is the younger result, so it wins over MEM/WB.
    // x0 is hard-wired to zero and is never forwarded.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        fwd_a = rs1_data;
        fwd_b = rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs1)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs1)) begin
            fwd_a = memwb_wdata;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs2)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs2)) begin
            fwd_b = memwb_wdata;
        end
    end

`ifdef OPERAND_ISOLATION_EN
    assign alu_a         = ex_valid ? fwd_a : '0;
    assign alu_b         = ex_valid ? (alu_src ? imm : fwd_b) : '0;
    assign ex_store_data = ex_valid ? fwd_b : '0;
    assign alu_ctrl_o    = ex_valid ? ex_alu_ctrl : 4'd0;
`else
    assign alu_a         = fwd_a;
    assign alu_b         = alu_src ? imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign alu_ctrl_o    = ex_alu_ctrl;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Directed self-checking bench for ex_operand_stage. Each vector's expected
// values are worked out by hand from the stage's behaviour.
// -----------------------------------------------------------------------------
module tb_ex_operand_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic            id_uses_rs2;
    logic [3:0]      id_alu_ctrl;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            stall;
    logic            flush;
    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_wdata;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl_o;
    logic            ex_valid;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [REGW-1:0] ex_rd;
    logic [XLEN-1:0] ex_store_data;
    logic            load_use_stall;

    int total = 0;
    int bad   = 0;

    ex_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_alu_src      (id_alu_src),
        .id_uses_rs2     (id_uses_rs2),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_wdata     (memwb_wdata),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctrl_o      (alu_ctrl_o),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_rd           (ex_rd),
        .ex_store_data   (ex_store_data),
        .load_use_stall  (load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with live-looking decode inputs. Reset must override them.
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_imm = 32'd0;
        id_alu_src = 1'b0; id_uses_rs2 = 1'b1; id_alu_ctrl = 4'b0010;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd6;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
        stall = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_wdata = '0;
        step();
        step();
        check("rst ex_valid",     {31'd0, ex_valid},     32'd0);
        check("rst ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst ex_mem_read",  {31'd0, ex_mem_read},  32'd0);
        check("rst ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
        check("rst ex_rd",        {27'd0, ex_rd},        32'd0);
        check("rst alu_ctrl_o",   {28'd0, alu_ctrl_o},   32'd0);
        check("rst load_use",     {31'd0, load_use_stall}, 32'd0);
        check("rst alu_a",        alu_a,         32'd0);
        check("rst alu_b",        alu_b,         32'd0);
        check("rst store_data",   ex_store_data, 32'd0);

        // Basic capture with one cycle of latency.
        rst_n = 1'b1;
        step();
        check("cap alu_a",      alu_a, 32'd5);
        check("cap alu_b",      alu_b, 32'd7);
        check("cap alu_ctrl_o", {28'd0, alu_ctrl_o}, 32'h2);
        check("cap ex_valid",   {31'd0, ex_valid}, 32'd1);
        check("cap ex_reg_write", {31'd0, ex_reg_write}, 32'd1);
        check("cap ex_rd",      {27'd0, ex_rd}, 32'd6);

        // Forwarding priority on rs1 = x3.
        id_rs1 = 5'd3; id_rs1_data = 32'h11; id_rd = 5'd7;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wdata  = 32'hBB;
        #1;
        check("fwd exmem wins", alu_a, 32'hAA);
        exmem_reg_write = 1'b0;
        #1;
        check("fwd memwb", alu_a, 32'hBB);
        memwb_reg_write = 1'b0;
        #1;
        check("fwd none", alu_a, 32'h11);

        // Index 0 is never forwarded.
        id_rs1 = 5'd0; id_rs1_data = 32'h22;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0;
        #1;
        check("fwd x0", alu_a, 32'h22);
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // A load to x4 enters EX.
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd4;
        id_mem_read = 1'b1; id_reg_write = 1'b1;
        step();
        check("load ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        // The dependent instruction reads x4 through rs2.
        id_mem_read = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd4; id_rd = 5'd8;
        id_uses_rs2 = 1'b1; id_rs2_data = 32'h99;
        #1;
        check("lu stall rs2", {31'd0, load_use_stall}, 32'd1);
        id_uses_rs2 = 1'b0;
        #1;
        check("lu no rs2 use", {31'd0, load_use_stall}, 32'd0);
        id_uses_rs2 = 1'b1;
        // A downstream stall holds the load in EX, so the request persists.
        stall = 1'b1;
        step();
        check("lu+stall mem_read", {31'd0, ex_mem_read},    32'd1);
        check("lu+stall request",  {31'd0, load_use_stall}, 32'd1);
        stall = 1'b0;
        step();
        check("lu bubble valid", {31'd0, ex_valid},       32'd0);
        check("lu bubble mrd",   {31'd0, ex_mem_read},    32'd0);
        check("lu bubble req",   {31'd0, load_use_stall}, 32'd0);
        step();
        check("lu dep valid", {31'd0, ex_valid}, 32'd1);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_wdata = 32'h44;
        #1;
        check("lu dep memwb fwd", alu_b, 32'h44);
        memwb_reg_write = 1'b0;

        // Stall for three cycles while the decode fields change.
        id_valid = 1'b1; id_alu_ctrl = 4'b0110;
        id_rs1 = 5'd8; id_rs1_data = 32'h100; id_rs2 = 5'd9; id_rs2_data = 32'h200;
        id_rd = 5'd10; id_alu_src = 1'b0; id_reg_write = 1'b1;
        step();
        check("pre-stall alu_a", alu_a, 32'h100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_rs1_data = 32'(i * 3 + 1);
            id_rs2_data = 32'(i * 5 + 2);
            id_alu_ctrl = 4'(i);
            id_rd = 5'(i + 20);
            step();
            check("stall alu_a",  alu_a, 32'h100);
            check("stall alu_b",  alu_b, 32'h200);
            check("stall ctrl",   {28'd0, alu_ctrl_o}, 32'h6);
            check("stall rd",     {27'd0, ex_rd}, 32'd10);
        end
        // Flush wins over stall.
        flush = 1'b1;
        step();
        check("flush+stall valid", {31'd0, ex_valid},     32'd0);
        check("flush+stall regwr", {31'd0, ex_reg_write}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Immediate on operand B; rs2 forwarded only into the store data.
        id_alu_src = 1'b1; id_imm = 32'hFFFF_FFF0;
        id_rs1 = 5'd0; id_rs2 = 5'd5; id_rs2_data = 32'h3;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'd9;
        #1;
        check("imm alu_b",      alu_b,         32'hFFFF_FFF0);
        check("imm store fwd",  ex_store_data, 32'd9);

        // Bubble with unchanged decode fields.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("bubble valid", {31'd0, ex_valid}, 32'd0);
`ifdef OPERAND_ISOLATION_EN
        check("bubble alu_b",  alu_b,         32'd0);
        check("bubble store",  ex_store_data, 32'd0);
        check("bubble ctrl",   {28'd0, alu_ctrl_o}, 32'd0);
`else
        check("bubble alu_b",  alu_b,         32'hFFFF_FFF0);
        check("bubble store",  ex_store_data, 32'd9);
`endif
        exmem_reg_write = 1'b0;

        // Invalid decode slot: control bits are masked by id_valid.
        id_valid = 1'b0; id_reg_write = 1'b1; id_mem_write = 1'b1;
        step();
        check("inv regwr", {31'd0, ex_reg_write}, 32'd0);
        check("inv memwr", {31'd0, ex_mem_write}, 32'd0);

        // A valid store, then reset asserted during a stall.
        id_valid = 1'b1;
        step();
        check("store memwr", {31'd0, ex_mem_write}, 32'd1);
        stall = 1'b1; rst_n = 1'b0;
        step();
        check("rst mid-stall valid", {31'd0, ex_valid},     32'd0);
        check("rst mid-stall memwr", {31'd0, ex_mem_write}, 32'd0);
        check("rst mid-stall rd",    {27'd0, ex_rd},        32'd0);
        stall = 1'b0; rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that directly feeds the ALU in the 5-stage pipeline. It captures decoded instruction fields each cycle and resolves EX/MEM and MEM/WB forwarding. It presents `alu_a`, `alu_b` and `alu_ctrl_o` to the ALU, and raises the load-use stall request to decode. It also supports pipeline stall and flush so the hazard and branch logic can hold or kill the EX slot.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `REGW`, 5, register-index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_valid` in 1: the decode slot holds a real instruction.
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_alu_src` in 1: 1 selects the immediate for operand B.
- `id_uses_rs2` in 1: the instruction reads rs2.
- `id_alu_ctrl` in 4: ALU operation code, same encoding as the ALU.
- `id_rs1`, `id_rs2`, `id_rd` in REGW: register indices.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits.
- `stall` in 1: downstream hold.
- `flush` in 1: kill the EX slot (taken branch/jump).
- `exmem_reg_write` in 1, `exmem_rd` in REGW, `exmem_result` in XLEN: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in REGW, `memwb_wdata` in XLEN: MEM/WB forwarding source.
- `alu_a`, `alu_b` out XLEN: ALU operands.
- `alu_ctrl_o` out 4: ALU operation.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control bits.
- `ex_rd` out REGW: destination register.
- `ex_store_data` out XLEN: forwarded rs2 value, used as store data.
- `load_use_stall` out 1: decode must hold this cycle.

## Operation
- State is one register set: `ex_valid`, control bits, `ex_alu_ctrl`, indices, `rs1_data`, `rs2_data`, `imm`, `alu_src`.
- Update priority at each edge:
  1. `!rst_n`: everything cleared to 0.
  2. `flush`: load a bubble. `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` go to 0. Data fields are don't-care.
  3. `stall`: hold all state.
  4. `load_use_stall`: load a bubble, the same as flush.
  5. Otherwise, capture all `id_*` fields. `ex_valid` takes `id_valid`. All control bits are ANDed with `id_valid`.
- `load_use_stall` is combinational. It is 1 only when all of the following hold:
  - `id_valid`, `ex_valid` and `ex_mem_read` are 1;
  - `ex_rd` is not 0;
  - `ex_rd` equals `id_rs1`, or `id_uses_rs2` is 1 and `ex_rd` equals `id_rs2`.
- Forwarding for each source (rs1, rs2), combinational on the registered index:
  - Use `exmem_result` if `exmem_reg_write` is 1, `exmem_rd` is not 0 and `exmem_rd` matches the index.
  - Otherwise use `memwb_wdata` under the same conditions on the MEM/WB source.
  - Otherwise use the registered data.
- EX/MEM wins over MEM/WB. Index 0 is never forwarded.
- `alu_a` is forwarded rs1. `alu_b` is `imm` when `alu_src` is 1, else forwarded rs2.
- `ex_store_data` is always forwarded rs2.
- `alu_ctrl_o` is `ex_alu_ctrl`.
- All arithmetic is XLEN-wide; no width extension happens here.

## Timing
- Latency: `id_*` fields appear on the outputs one cycle after capture. The forwarding result is valid in the same cycle the forwarding inputs change (combinational path).
- Reset values:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_rd`, `alu_ctrl_o` and `load_use_stall` are 0.
  - `alu_a`, `alu_b` and `ex_store_data` are 0, because registered indices are 0 and index 0 is never forwarded.
- `flush` and `stall` in the same cycle: flush wins.
- `stall` and `load_use_stall` in the same cycle: the slot holds. The load stays in EX and the stall request persists.
- After one bubble, `ex_mem_read` is 0, so `load_use_stall` deasserts. The dependent instruction then captures and picks up the load data via the MEM/WB path one cycle later.
- `rst_n` low mid-stall or mid-flush: reset takes effect at that edge, overriding all else.

## Configuration
- `OPERAND_ISOLATION_EN` defined:
  - `alu_a`, `alu_b`, `ex_store_data` and `alu_ctrl_o` are forced to 0 whenever `ex_valid` is 0.
  - Data registers are not loaded on a bubble or while `id_valid` is 0, which suppresses ALU toggling.
- Not defined:
  - Outputs follow the registers unconditionally.
  - Data fields load on every non-stalled edge, regardless of valid.

## Test plan
- Reset, then `id_valid`=1, `id_alu_ctrl`=0010, `rs1_data`=5, `rs2_data`=7, no forwarding -> next cycle `alu_a`=5, `alu_b`=7, `alu_ctrl_o`=0010, `ex_valid`=1.
- EX rs1=3 with `exmem_rd`=3, `exmem_result`=0xAA, `memwb_rd`=3, `memwb_wdata`=0xBB -> `alu_a`=0xAA. Dropping `exmem_reg_write` -> `alu_a`=0xBB. With rs1=0 and `exmem_rd`=0 -> register data, never forwarded.
- Load with rd=4 in EX, `id_rs2`=4, `id_uses_rs2`=1 -> `load_use_stall`=1. Next cycle `ex_valid`=0, `load_use_stall`=0. With `id_uses_rs2`=0 -> no stall.
- `stall`=1 for 3 cycles while `id_*` fields change -> outputs unchanged. `flush`=1 together with `stall`=1 -> next cycle `ex_valid`=0 and `ex_reg_write`=0.
- `id_alu_src`=1, `imm`=0xFFFFFFF0, and rs2 forwarded to 9 -> `alu_b`=0xFFFFFFF0, `ex_store_data`=9.
- With `OPERAND_ISOLATION_EN`: a bubble cycle -> `alu_a`=`alu_b`=0 and `alu_ctrl_o`=0. Without it -> the previous operands persist.
